// File: rtl/pc_gen_pkg.sv
// Shared CPU definitions for the fetch-address generator: reset/exception
// addresses and the redirect FSM state encoding.
package pc_gen_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_4180;

  // RUN: no redirect outstanding. HOLD: a redirect target is parked while stalled.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_adder.sv
// Constant-increment adder used for the sequential and link addresses.
// Result wraps modulo 2^WIDTH.
module pc_adder #(
  parameter int WIDTH = 32,
  parameter int INC   = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + WIDTH'(INC);

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: prioritised next-PC selection with a one-entry
// pending-redirect register that keeps branch/jump targets alive across stalls.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               STEP       = 4,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(RESET_PC_DEFAULT),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(EXC_VECTOR_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             exc_req,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_seq,
  output logic [WIDTH-1:0] pc_link,
  output logic             pend,
  output logic             misalign
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

  pc_state_e        state;
  logic [WIDTH-1:0] pend_target;
  logic [WIDTH-1:0] redirect_target;

  pc_adder #(.WIDTH(WIDTH), .INC(STEP)) u_seq_adder (
    .a   (pc),
    .sum (pc_seq)
  );

  pc_adder #(.WIDTH(WIDTH), .INC(2 * STEP)) u_link_adder (
    .a   (pc),
    .sum (pc_link)
  );

  // Jump outranks a simultaneous taken branch.
  assign redirect_target = jump ? jump_target : br_target;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      pend_target <= '0;
      state       <= ST_RUN;
    end else if (exc_req) begin
      pc    <= EXC_VECTOR;
      state <= ST_RUN;
    end else if (eret) begin
      pc    <= epc;
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (!stall) begin
            pc <= (jump || br_taken) ? redirect_target : pc_seq;
          end else if (jump || br_taken) begin
            pend_target <= redirect_target;
            state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Requests arriving while a target is parked are dropped.
          if (!stall) begin
            pc    <= pend_target;
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign pend     = (state == ST_HOLD);
  assign misalign = |(pc & ALIGN_MASK);

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pc_gen;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         stall;
  logic         br_taken;
  logic [W-1:0] br_target;
  logic         jump;
  logic [W-1:0] jump_target;
  logic         exc_req;
  logic         eret;
  logic [W-1:0] epc;
  logic [W-1:0] pc;
  logic [W-1:0] pc_seq;
  logic [W-1:0] pc_link;
  logic         pend;
  logic         misalign;

  int tests;
  int fails;

  pc_gen dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jump        (jump),
    .jump_target (jump_target),
    .exc_req     (exc_req),
    .eret        (eret),
    .epc         (epc),
    .pc          (pc),
    .pc_seq      (pc_seq),
    .pc_link     (pc_link),
    .pend        (pend),
    .misalign    (misalign)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // What the PC must be, computed from the architectural rules each edge.
  logic [W-1:0] m_pc;
  logic [W-1:0] m_tgt;
  bit           m_pend;
  bit           model_ok;

  initial begin
    model_ok = 0;
    m_pc     = '0;
    m_tgt    = '0;
    m_pend   = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 32'h0000_3000; m_pend = 0; m_tgt = '0; model_ok = 1;
    end else if (exc_req) begin
      m_pc = 32'h0000_4180; m_pend = 0;
    end else if (eret) begin
      m_pc = epc; m_pend = 0;
    end else if (stall) begin
      if (!m_pend && (jump || br_taken)) begin
        m_pend = 1;
        m_tgt  = jump ? jump_target : br_target;
      end
    end else if (m_pend) begin
      m_pc = m_tgt; m_pend = 0;
    end else if (jump) begin
      m_pc = jump_target;
    end else if (br_taken) begin
      m_pc = br_target;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  end

  // Compare on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      check("cyc_pc",       pc,             m_pc);
      check("cyc_pc_seq",   pc_seq,         m_pc + 32'd4);
      check("cyc_pc_link",  pc_link,        m_pc + 32'd8);
      check("cyc_pend",     W'(pend),       W'(m_pend));
      check("cyc_misalign", W'(misalign),   W'((m_pc % 4) != 0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; br_taken = 0; jump = 0; exc_req = 0; eret = 0;
  endtask

  task automatic random_cycle();
    reset       = ($urandom_range(0, 199) == 0);
    stall       = ($urandom_range(0, 2) == 0);
    jump        = ($urandom_range(0, 5) == 0);
    br_taken    = ($urandom_range(0, 4) == 0);
    exc_req     = ($urandom_range(0, 39) == 0);
    eret        = ($urandom_range(0, 39) == 0);
    jump_target = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
    br_target   = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
    epc         = $urandom & 32'hFFFF_FFFC;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tests = 0;
    fails = 0;
    reset = 1; br_target = '0; jump_target = '0; epc = '0;
    idle_inputs();
    tick();
    tick();
    reset = 0;
    check("rst_pc",       pc,           32'h0000_3000);
    check("rst_pc_seq",   pc_seq,       32'h0000_3004);
    check("rst_pc_link",  pc_link,      32'h0000_3008);
    check("rst_pend",     W'(pend),     32'd0);
    check("rst_misalign", W'(misalign), 32'd0);

    // Free-running sequence
    tick(); check("seq_3004", pc, 32'h0000_3004);
    tick(); check("seq_3008", pc, 32'h0000_3008);
    check("seq_link", pc_link, 32'h0000_3010);
    tick(); check("seq_300c", pc, 32'h0000_300C);
    tick(); check("seq_3010", pc, 32'h0000_3010);

    // Taken branch, unstalled: one-cycle latency
    br_taken = 1; br_target = 32'h0000_3100;
    tick(); check("br_pc", pc, 32'h0000_3100);
    br_taken = 0;
    tick(); check("br_after", pc, 32'h0000_3104);

    // Jump captured while stalled; later branch ignored
    stall = 1; jump = 1; jump_target = 32'h0000_3200;
    tick(); check("hold_pc1", pc, 32'h0000_3104); check("hold_pend1", W'(pend), 32'd1);
    jump = 0; br_taken = 1; br_target = 32'h0000_3300;
    tick(); check("hold_pc2", pc, 32'h0000_3104); check("hold_pend2", W'(pend), 32'd1);
    br_taken = 0; stall = 0;
    tick(); check("rel_pc", pc, 32'h0000_3200); check("rel_pend", W'(pend), 32'd0);

    // Exception overrides a pending redirect, then eret
    stall = 1; jump = 1; jump_target = 32'h0000_3208;
    tick(); check("exc_pre_pend", W'(pend), 32'd1);
    jump = 0; exc_req = 1;
    tick(); check("exc_pc", pc, 32'h0000_4180); check("exc_pend", W'(pend), 32'd0);
    exc_req = 0; eret = 1; epc = 32'h0000_3204;
    tick(); check("eret_pc", pc, 32'h0000_3204);
    eret = 0; stall = 0;

    // Wrap-around and misaligned target
    jump = 1; jump_target = 32'hFFFF_FFFC;
    tick(); check("wrap_pre", pc, 32'hFFFF_FFFC); check("wrap_link", pc_link, 32'h0000_0004);
    jump = 0;
    tick(); check("wrap_pc", pc, 32'h0000_0000);
    jump = 1; jump_target = 32'h0000_3002;
    tick(); check("mis_pc", pc, 32'h0000_3002); check("mis_flag", W'(misalign), 32'd1);
    jump = 0;

    // Reset during HOLD
    stall = 1; jump = 1; jump_target = 32'h0000_3400;
    tick(); check("rh_pend", W'(pend), 32'd1);
    reset = 1;
    tick(); check("rh_pc", pc, 32'h0000_3000); check("rh_pend0", W'(pend), 32'd0);
    reset = 0; idle_inputs();
    tick(); check("rh_after", pc, 32'h0000_3004);

    // Randomized traffic, checked each cycle by the model
    for (int i = 0; i < 3000; i++) random_cycle();
    reset = 0;
    idle_inputs();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning PC width in bits.
REQ-002 SHALL have parameter STEP, default 4, meaning sequential increment; power of two, at least 1.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning PC value after reset.
REQ-004 SHALL have parameter EXC_VECTOR, default 32'h0000_4180, meaning exception handler entry.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port stall, input, 1 bit: hold the PC (fetch stage frozen).
REQ-008 SHALL have port br_taken, input, 1 bit: conditional branch resolved taken this cycle.
REQ-009 SHALL have port br_target, input, WIDTH bits: branch destination.
REQ-010 SHALL have port jump, input, 1 bit: unconditional jump or jump-register this cycle.
REQ-011 SHALL have port jump_target, input, WIDTH bits: jump destination.
REQ-012 SHALL have port exc_req, input, 1 bit: take exception, redirect to EXC_VECTOR.
REQ-013 SHALL have port eret, input, 1 bit: return from exception.
REQ-014 SHALL have port epc, input, WIDTH bits: eret destination.
REQ-015 SHALL have port pc, output, WIDTH bits: current fetch address (registered).
REQ-016 SHALL have port pc_seq, output, WIDTH bits: pc + STEP (combinational).
REQ-017 SHALL have port pc_link, output, WIDTH bits: pc + 2*STEP (delay-slot link address, combinational).
REQ-018 SHALL have port pend, output, 1 bit: a redirect is held pending.
REQ-019 SHALL have port misalign, output, 1 bit: pc low log2(STEP) bits nonzero (combinational).

Function
REQ-020 SHALL apply next-PC priority exc_req > eret > pending redirect > jump > br_taken > sequential.
REQ-021 SHALL load EXC_VECTOR on exc_req, or epc on eret, regardless of stall, and SHALL clear pend in the same cycle.
REQ-022 SHALL, with stall=0 and no exc_req or eret: if pend=1, load the pending target and clear pend; otherwise load jump_target, else br_target, else pc_seq.
REQ-023 SHALL, with stall=1 and no exc_req or eret, hold pc unchanged.
REQ-024 SHALL, with stall=1 and pend=0, capture jump_target (jump) or br_target (br_taken only) into the pending register and set pend on the next edge.
REQ-025 SHALL, with stall=1 and pend=1, ignore new jump and br_taken requests; the older captured target is retained.
REQ-026 SHALL operate as a two-state FSM: RUN (pend=0) and HOLD (pend=1).
  - RUN to HOLD on stall and (jump or br_taken) with no exc_req or eret.
  - HOLD to RUN on stall=0, or on exc_req or eret.
REQ-027 SHALL compute all additions modulo 2^WIDTH; wrap-around is silent.
REQ-028 SHALL load misaligned targets unchanged and flag them only via misalign; the block does no exception generation itself.
REQ-029 SHALL give a redirect with stall=0 a latency of one cycle: target visible on pc after the next edge.

Reset
REQ-030 SHALL, on reset=1 at a clock edge, set pc=RESET_PC, clear pend and the pending target, and set the FSM to RUN; reset overrides all other inputs.
REQ-031 SHALL present pc_seq=RESET_PC+STEP, pc_link=RESET_PC+2*STEP and misalign=0 (for the default RESET_PC) after reset.

Structure
REQ-032 SHALL take the defaults for RESET_PC and EXC_VECTOR, and the FSM state encoding, from the shared CPU package.
REQ-033 SHALL instantiate one parametrised sub-module, pc_adder (WIDTH, INC), twice, for pc_seq (INC=STEP) and pc_link (INC=2*STEP).

Verification
REQ-034 SHALL verify: reset, then 3 free-running cycles -> pc = 3000, 3004, 3008, 300C; pc_link = pc+8.
REQ-035 SHALL verify: at pc=3010, br_taken=1, br_target=3100, stall=0 -> pc=3100 next cycle, then 3104.
REQ-036 SHALL verify: stall=1 with jump=1, jump_target=3200; next cycle br_taken=1, br_target=3300, still stalled; release stall -> pend=1 while stalled, pc frozen, then pc=3200, pend=0.
REQ-037 SHALL verify: stall=1, pend=1, plus exc_req=1 -> pc=4180, pend=0; then eret=1, epc=3204 -> pc=3204.
REQ-038 SHALL verify: pc=FFFFFFFC, sequential step -> pc=00000000; jump_target=3002 -> misalign=1.
REQ-039 SHALL verify: reset asserted during HOLD -> pc=3000, pend=0 next cycle.
